ad7606_frame_packer: RTL

- Downstream consumer of the AD7606 driver's eight per-channel user outputs (data_1..8 / valid_1..8).
- Collects one complete 8-channel sample set, snapshots it into a transmit buffer, and emits it as a 20-byte framed byte stream.
- Byte stream uses a valid/ready handshake toward a UART/FIFO sender.
- Frame layout: header, sequence number, 16 data bytes, 8-bit checksum.

---
 rtl/ad7606_frame_packer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ad7606_frame_packer.sv
// Gathers one 8-channel AD7606 sample set and streams it as a 20-byte frame:
// HDR0 HDR1 SEQ, 16 data bytes (ch1 MSB first), then an 8-bit sum of SEQ+data.
module ad7606_frame_packer #(
    parameter logic [7:0] P_HDR0 = 8'hA5,
    parameter logic [7:0] P_HDR1 = 8'h5A
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [15:0] i_user_data_1,
    input  logic [15:0] i_user_data_2,
    input  logic [15:0] i_user_data_3,
    input  logic [15:0] i_user_data_4,
    input  logic [15:0] i_user_data_5,
    input  logic [15:0] i_user_data_6,
    input  logic [15:0] i_user_data_7,
    input  logic [15:0] i_user_data_8,
    input  logic        i_user_valid_1,
    input  logic        i_user_valid_2,
    input  logic        i_user_valid_3,
    input  logic        i_user_valid_4,
    input  logic        i_user_valid_5,
    input  logic        i_user_valid_6,
    input  logic        i_user_valid_7,
    input  logic        i_user_valid_8,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_tx_sof,
    output logic        o_tx_eof,
    output logic        o_busy,
    output logic [15:0] o_drop_cnt
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_SEQ,
        S_DATA,
        S_CSUM
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         seq_q, seq_d;
    logic [7:0]         csum_q, csum_d;
    logic [7:0]         mask_q, mask_d;
    logic [15:0]        drop_q, drop_d;
    logic signed [15:0] cap_q   [8];
    logic signed [15:0] cap_d   [8];
    logic signed [15:0] txbuf_q [8];
    logic signed [15:0] txbuf_d [8];
    logic signed [15:0] in_data [8];
    logic [7:0]         in_vld;
    logic               mask_full;
    logic               hs;
    logic [15:0]        cur_word;
    logic [7:0]         data_byte;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign in_data[0] = i_user_data_1;
    assign in_data[1] = i_user_data_2;
    assign in_data[2] = i_user_data_3;
    assign in_data[3] = i_user_data_4;
    assign in_data[4] = i_user_data_5;
    assign in_data[5] = i_user_data_6;
    assign in_data[6] = i_user_data_7;
    assign in_data[7] = i_user_data_8;

    // Disabled capture behaves as if no strobes arrived.
    assign in_vld = {i_user_valid_8, i_user_valid_7, i_user_valid_6, i_user_valid_5,
                     i_user_valid_4, i_user_valid_3, i_user_valid_2, i_user_valid_1}
                    & {8{i_enable}};

    assign mask_full  = (mask_q == 8'hFF);
    assign hs         = o_tx_valid & i_tx_ready;
    assign o_busy     = (state_q != S_IDLE);
    assign o_drop_cnt = drop_q;

    always_comb begin
        cur_word  = txbuf_q[idx_q[3:1]];
        data_byte = idx_q[0] ? cur_word[7:0] : cur_word[15:8];
    end

    always_comb begin
        o_tx_data  = 8'h00;
        o_tx_valid = 1'b0;
        o_tx_sof   = 1'b0;
        o_tx_eof   = 1'b0;
        case (state_q)
            S_HDR0: begin
                o_tx_data  = P_HDR0;
                o_tx_valid = 1'b1;
                o_tx_sof   = 1'b1;
            end
            S_HDR1: begin
                o_tx_data  = P_HDR1;
                o_tx_valid = 1'b1;
            end
            S_SEQ: begin
                o_tx_data  = seq_q;
                o_tx_valid = 1'b1;
            end
            S_DATA: begin
                o_tx_data  = data_byte;
                o_tx_valid = 1'b1;
            end
            S_CSUM: begin
                o_tx_data  = csum_q;
                o_tx_valid = 1'b1;
                o_tx_eof   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        csum_d  = csum_q;
        drop_d  = drop_q;
        cap_d   = cap_q;
        txbuf_d = txbuf_q;

        for (int k = 0; k < 8; k++) begin
            if (in_vld[k]) cap_d[k] = in_data[k];
        end

        if (!i_enable)      mask_d = 8'h00;
        else if (mask_full) mask_d = in_vld;
        else                mask_d = mask_q | in_vld;

        // The snapshot uses the registered captures; this cycle's strobes seed the next set.
        if (mask_full) begin
            if (state_q == S_IDLE) begin
                txbuf_d = cap_q;
                csum_d  = 8'h00;
                state_d = S_HDR0;
            end else begin
                drop_d = sat_inc16(drop_q);
            end
        end

        if (hs) begin
            case (state_q)
                S_HDR0: state_d = S_HDR1;
                S_HDR1: state_d = S_SEQ;
                S_SEQ: begin
                    csum_d  = csum_q + seq_q;
                    idx_d   = 4'd0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    csum_d = csum_q + data_byte;
                    if (idx_q == 4'd15) state_d = S_CSUM;
                    else                idx_d   = idx_q + 4'd1;
                end
                S_CSUM: begin
                    seq_d   = seq_q + 8'd1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            seq_q   <= 8'h00;
            csum_q  <= 8'h00;
            mask_q  <= 8'h00;
            drop_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            csum_q  <= csum_d;
            mask_q  <= mask_d;
            drop_q  <= drop_d;
        end
    end

    // Sample storage is qualified by mask/state, so it carries no reset.
    always_ff @(posedge i_clk) begin
        cap_q   <= cap_d;
        txbuf_q <= txbuf_d;
    end

endmodule
